// File: rtl/jtframe_dly_pkg.sv
// jtframe_dly_pkg: state encoding and helpers shared by the jtframe_dly_ctrl delay line
package jtframe_dly_pkg;

    typedef enum logic {
        ST_FLUSH = 1'b0,
        ST_RUN   = 1'b1
    } dly_st_t;

    function automatic int unsigned depth(input int unsigned aw);
        return 32'd1 << aw;
    endfunction

    // A delay of zero would read and write the same slot, so it becomes one.
    function automatic int unsigned dly_clamp(input int unsigned d);
        return (d == 32'd0) ? 32'd1 : d;
    endfunction

endpackage

// File: rtl/jtframe_dly_ram.sv
// jtframe_dly_ram: simple dual-port sample buffer, one write port and one registered read port, both gated by cen
module jtframe_dly_ram
    import jtframe_dly_pkg::*;
#(
    parameter int DW = 8,
    parameter int AW = 6
) (
    input  logic          clk,
    input  logic          cen,
    input  logic [AW-1:0] i_waddr,
    input  logic [AW-1:0] i_raddr,
    input  logic [DW-1:0] i_din,
    output logic [DW-1:0] o_q
);

    logic [DW-1:0] r_mem [depth(AW)];
    logic [DW-1:0] r_q;

    // Write and registered read share the cen; a colliding read returns the old word.
    always_ff @(posedge clk) begin
        if (cen) begin
            r_mem[i_waddr] <= i_din;
            r_q            <= r_mem[i_raddr];
        end
    end

    assign o_q = r_q;

endmodule

// File: rtl/jtframe_dly_ctrl.sv
// jtframe_dly_ctrl: run-time programmable BRAM delay line; JTFRAME_DLY_HOLD_EN keeps the last output during flush
module jtframe_dly_ctrl
    import jtframe_dly_pkg::*;
#(
    parameter int DW      = 8,
    parameter int AW      = 6,
    parameter int DLY_RST = 4
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          cen,
    input  logic [DW-1:0] din,
    input  logic [AW-1:0] dly,
    input  logic          dly_we,
    output logic          busy,
    output logic [DW-1:0] dout,
    output logic          dout_valid
);

    localparam logic [AW-1:0] DLY_INIT = AW'(DLY_RST);

    dly_st_t       r_st, w_st_nxt;
    logic [AW-1:0] r_wr_ptr, r_dly_cur, r_cnt;
    logic [AW-1:0] w_dly_cur_nxt, w_cnt_nxt, w_dly_ld, w_raddr;
    logic          r_src, r_valid;
    logic [DW-1:0] w_q, w_hold;

    assign w_dly_ld = AW'(dly_clamp(32'(dly)));
    assign w_raddr  = r_wr_ptr - r_dly_cur;

    jtframe_dly_ram #(.DW(DW), .AW(AW)) u_ram (
        .clk     (clk),
        .cen     (cen),
        .i_waddr (r_wr_ptr),
        .i_raddr (w_raddr),
        .i_din   (din),
        .o_q     (w_q)
    );

    // A load always restarts the flush; otherwise each cen in FLUSH counts down towards RUN.
    always_comb begin
        w_st_nxt      = r_st;
        w_cnt_nxt     = r_cnt;
        w_dly_cur_nxt = r_dly_cur;
        if (dly_we) begin
            w_st_nxt      = ST_FLUSH;
            w_cnt_nxt     = w_dly_ld;
            w_dly_cur_nxt = w_dly_ld;
        end else if (cen && r_st == ST_FLUSH) begin
            w_cnt_nxt = r_cnt - 1'b1;
            if (r_cnt == AW'(1))
                w_st_nxt = ST_RUN;
        end
    end

    // FSM state, flush counter and active delay.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_st      <= ST_FLUSH;
            r_cnt     <= DLY_INIT;
            r_dly_cur <= DLY_INIT;
        end else begin
            r_st      <= w_st_nxt;
            r_cnt     <= w_cnt_nxt;
            r_dly_cur <= w_dly_cur_nxt;
        end
    end

    // Write pointer and output qualifiers advance with cen; a load drops valid at once.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_wr_ptr <= '0;
            r_src    <= 1'b0;
            r_valid  <= 1'b0;
        end else begin
            if (cen) begin
                r_wr_ptr <= r_wr_ptr + 1'b1;
                r_src    <= (r_st == ST_RUN);
            end
            if (dly_we)
                r_valid <= 1'b0;
            else if (cen)
                r_valid <= (r_st == ST_RUN);
        end
    end

`ifdef JTFRAME_DLY_HOLD_EN
    logic [DW-1:0] r_hold;

    // Track the presented sample so a flush keeps showing the last RUN value.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)
            r_hold <= '0;
        else if (cen)
            r_hold <= dout;
    end

    assign w_hold = r_hold;
`else
    assign w_hold = '0;
`endif

    assign busy       = (r_st == ST_FLUSH);
    assign dout       = r_src ? w_q : w_hold;
    assign dout_valid = r_valid;

endmodule

// File: tb/tb_jtframe_dly_ctrl.sv
// tb_jtframe_dly_ctrl: table-driven and directed checks for jtframe_dly_ctrl
module tb_jtframe_dly_ctrl;

    localparam int DW = 8;
    localparam int AW = 6;
`ifdef JTFRAME_DLY_HOLD_EN
    localparam bit HOLD = 1'b1;
`else
    localparam bit HOLD = 1'b0;
`endif

    typedef struct {
        logic          c;
        logic          w;
        logic [AW-1:0] d;
        logic [DW-1:0] x;
        logic          b;
        logic          v;
        logic [DW-1:0] o;
        logic [DW-1:0] oh;
    } vec_t;

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic          cen = 1'b0;
    logic          dly_we = 1'b0;
    logic [DW-1:0] din = '0;
    logic [AW-1:0] dly = '0;
    logic          busy, dout_valid;
    logic [DW-1:0] dout;

    int checks = 0;
    int failures = 0;

    always #5 clk = ~clk;

    jtframe_dly_ctrl #(.DW(DW), .AW(AW), .DLY_RST(4)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .cen        (cen),
        .din        (din),
        .dly        (dly),
        .dly_we     (dly_we),
        .busy       (busy),
        .dout       (dout),
        .dout_valid (dout_valid)
    );

    task automatic chk(input string name, input int idx, input int act, input int exp);
        checks++;
        if (act != exp) begin
            failures++;
            $display("FAIL %s[%0d]: got %0d expected %0d", name, idx, act, exp);
        end
    endtask

    task automatic step(input logic c, input logic w, input int d, input int x);
        @(negedge clk);
        cen    = c;
        dly_we = w;
        dly    = AW'(d);
        din    = DW'(x);
        @(posedge clk);
        #1;
        cen    = 1'b0;
        dly_we = 1'b0;
    endtask

    function automatic vec_t mk(input int c, w, d, x, b, v, o, oh);
        vec_t t;
        t.c = c[0]; t.w = w[0]; t.d = AW'(d); t.x = DW'(x);
        t.b = b[0]; t.v = v[0]; t.o = DW'(o); t.oh = DW'(oh);
        return t;
    endfunction

    vec_t tv[26];
    int   hist[0:255];
    int   last_run;
    int   exp_o;
    int   dv;

    initial begin
        tv[0]  = mk(1,0,0,1,   1,0,0,0);
        tv[1]  = mk(1,0,0,2,   1,0,0,0);
        tv[2]  = mk(1,0,0,3,   1,0,0,0);
        tv[3]  = mk(1,0,0,4,   0,0,0,0);
        tv[4]  = mk(1,0,0,5,   0,1,1,1);
        tv[5]  = mk(1,0,0,6,   0,1,2,2);
        tv[6]  = mk(0,0,0,99,  0,1,2,2);
        tv[7]  = mk(1,0,0,7,   0,1,3,3);
        tv[8]  = mk(1,0,0,8,   0,1,4,4);
        tv[9]  = mk(0,1,2,0,   1,0,4,4);
        tv[10] = mk(1,0,0,9,   1,0,0,4);
        tv[11] = mk(1,0,0,10,  0,0,0,4);
        tv[12] = mk(1,0,0,11,  0,1,9,9);
        tv[13] = mk(1,0,0,12,  0,1,10,10);
        tv[14] = mk(1,1,2,13,  1,0,11,11);
        tv[15] = mk(1,0,0,14,  1,0,0,11);
        tv[16] = mk(0,1,3,0,   1,0,0,11);
        tv[17] = mk(1,0,0,15,  1,0,0,11);
        tv[18] = mk(1,0,0,16,  1,0,0,11);
        tv[19] = mk(1,0,0,17,  0,0,0,11);
        tv[20] = mk(1,0,0,18,  0,1,15,15);
        tv[21] = mk(1,0,0,19,  0,1,16,16);
        tv[22] = mk(0,1,0,0,   1,0,16,16);
        tv[23] = mk(1,0,0,20,  0,0,0,16);
        tv[24] = mk(1,0,0,21,  0,1,20,20);
        tv[25] = mk(1,0,0,22,  0,1,21,21);

        repeat (3) @(posedge clk);
        #1;
        chk("rst_busy", 0, int'(busy), 1);
        chk("rst_valid", 0, int'(dout_valid), 0);
        chk("rst_dout", 0, int'(dout), 0);
        @(negedge clk);
        rst_n = 1'b1;

        for (int i = 0; i < 26; i++) begin
            step(tv[i].c, tv[i].w, int'(tv[i].d), int'(tv[i].x));
            chk("tbl_busy", i, int'(busy), int'(tv[i].b));
            chk("tbl_valid", i, int'(dout_valid), int'(tv[i].v));
            chk("tbl_dout", i, int'(dout), HOLD ? int'(tv[i].oh) : int'(tv[i].o));
        end
        last_run = 21;

        step(0, 1, 7, 0);
        for (int n = 1; n <= 30; n++) begin
            dv = (n * 37 + 5) & 255;
            hist[n] = dv;
            step(1, 0, 0, dv);
            exp_o = (n >= 8) ? hist[n-7] : (HOLD ? last_run : 0);
            chk("d7_busy", n, int'(busy), (n < 7) ? 1 : 0);
            chk("d7_valid", n, int'(dout_valid), (n >= 8) ? 1 : 0);
            chk("d7_dout", n, int'(dout), exp_o);
            step(0, 0, 0, 255 - dv);
            step(0, 0, 0, dv ^ 85);
            chk("d7_idle", n, int'(dout), exp_o);
            if (n >= 8) last_run = exp_o;
        end

        step(0, 1, 63, 0);
        for (int n = 1; n <= 200; n++) begin
            dv = (n * 53 + 11) & 255;
            hist[n] = dv;
            step(1, 0, 0, dv);
            chk("d63_busy", n, int'(busy), (n < 63) ? 1 : 0);
            chk("d63_valid", n, int'(dout_valid), (n >= 64) ? 1 : 0);
            chk("d63_dout", n, int'(dout), (n >= 64) ? hist[n-63] : (HOLD ? last_run : 0));
        end

        @(negedge clk);
        #2;
        rst_n = 1'b0;
        #1;
        chk("arst_busy", 0, int'(busy), 1);
        chk("arst_valid", 0, int'(dout_valid), 0);
        chk("arst_dout", 0, int'(dout), 0);
        @(negedge clk);
        rst_n = 1'b1;
        for (int k = 1; k <= 8; k++) begin
            step(1, 0, 0, k);
            chk("rec_busy", k, int'(busy), (k < 4) ? 1 : 0);
            chk("rec_valid", k, int'(dout_valid), (k >= 5) ? 1 : 0);
            chk("rec_dout", k, int'(dout), (k >= 5) ? k - 4 : 0);
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
